// File: rtl/free_list.sv
// free_list: circular free list of physical register tags for a rename stage.
// Dispatch pops up to three tags from the head. Retire pushes up to three
// stale tags at the tail. A branch-mispredict recovery marks every
// non-architectural tag as free.
// Optional build macro: FREE_LIST_DEBUG_EN adds raw entry and pointer outputs.

`ifndef PR
`define PR 6
`endif

module free_list (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             dispatch_num,
  output logic [2:0][`PR-1:0]    free_pr_out,
  output logic [5:0]             free_num,
  input  logic [2:0]             retire_valid,
  input  logic [2:0][`PR-1:0]    Told_in,
  input  logic                   BPRecoverEN
`ifdef FREE_LIST_DEBUG_EN
  ,
  output logic [31:0][`PR-1:0]   free_array_disp,
  output logic [4:0]             head_disp,
  output logic [4:0]             tail_disp
`endif
);

  localparam int FL_DEPTH = 32;
  localparam int PTR_W    = 5;
  localparam int CNT_W    = 6;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [`PR-1:0]   pr_t;

  // Storage and pointers.
  pr_t [FL_DEPTH-1:0] entries;
  ptr_t               head;
  ptr_t               tail;
  cnt_t               count;

  // Next-state values.
  ptr_t               head_next;
  ptr_t               tail_next;
  cnt_t               count_next;

  // Retire compaction and write control.
  pr_t  [2:0]         ret_pr;
  logic [1:0]         n_ret;
  logic [1:0]         consumed;
  logic [1:0]         accepted;
  logic [6:0]         space;
  logic [2:0]         wr_en;
  ptr_t [2:0]         wr_addr;

  // Read the three oldest free tags. Same-cycle retire writes are not
  // forwarded, so a retired tag appears here one cycle later.
  always_comb begin
    free_pr_out[2] = entries[head];
    free_pr_out[1] = entries[head + ptr_t'(1)];
    free_pr_out[0] = entries[head + ptr_t'(2)];
    free_num       = count;
  end

  // Pack the valid retire slots, oldest (slot 2) first.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so that n_ret, once
    // updated, is seen by the later loop iterations. Every output also gets
    // a default first, so no path leaves a value held and no latch is inferred.
    ret_pr = '0;
    n_ret  = '0;
    for (int s = 2; s >= 0; s--) begin
      if (retire_valid[s]) begin
        ret_pr[n_ret] = Told_in[s];
        n_ret         = n_ret + 2'd1;
      end
    end
  end

  // Find the amount consumed and retired this cycle, then the next pointers
  // and count.
  always_comb begin
    // A dispatch cannot take more tags than the list holds. During recovery
    // the dispatch request is ignored.
    consumed = '0;
    if (!BPRecoverEN) begin
      if ({4'b0, dispatch_num} > count) consumed = count[1:0];
      else                              consumed = dispatch_num;
    end

    // Room for retire writes counts the slots freed by this cycle's
    // dispatch. Any excess retire writes are dropped so live entries are
    // never overwritten.
    space = 7'(FL_DEPTH) - {1'b0, count} + {5'b0, consumed};
    if ({5'b0, n_ret} > space) accepted = space[1:0];
    else                       accepted = n_ret;

    tail_next = tail + ptr_t'(accepted);
    if (BPRecoverEN) begin
      head_next  = tail_next;
      count_next = cnt_t'(FL_DEPTH);
    end else begin
      head_next  = head + ptr_t'(consumed);
      count_next = count - cnt_t'(consumed) + cnt_t'(accepted);
    end

    for (int k = 0; k < 3; k++) begin
      wr_en[k]   = (2'(k) < accepted);
      wr_addr[k] = tail + ptr_t'(k);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= cnt_t'(FL_DEPTH);
    end else begin
      head  <= head_next;
      tail  <= tail_next;
      count <= count_next;
    end
  end

  // Entry storage: seeded with the non-architectural tags, written at the tail on retire.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: this array is reset on purpose. After reset it must hold tags
    // 32..63, so it is built from flops with async reset and not from a RAM
    // macro, which has no reset.
    if (!reset) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        entries[i] <= pr_t'(FL_DEPTH + i);
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (wr_en[k]) entries[wr_addr[k]] <= ret_pr[k];
      end
    end
  end

`ifdef FREE_LIST_DEBUG_EN
  // Raw state for debug visibility.
  always_comb begin
    free_array_disp = entries;
    head_disp       = head;
    tail_disp       = tail;
  end
`endif

endmodule

// File: tb/tb_free_list.sv
// tb_free_list: directed, table-driven bench for free_list. It also runs
// hand-written sequences for reset, latency, wrap-around and mid-operation
// reset.

`ifndef PR
`define PR 6
`endif

module tb_free_list;

  logic                clock = 1'b0;
  logic                reset;
  logic [1:0]          dispatch_num;
  logic [2:0][`PR-1:0] free_pr_out;
  logic [5:0]          free_num;
  logic [2:0]          retire_valid;
  logic [2:0][`PR-1:0] Told_in;
  logic                BPRecoverEN;
`ifdef FREE_LIST_DEBUG_EN
  logic [31:0][`PR-1:0] free_array_disp;
  logic [4:0]           head_disp;
  logic [4:0]           tail_disp;
`endif

  free_list dut (
    .clock        (clock),
    .reset        (reset),
    .dispatch_num (dispatch_num),
    .free_pr_out  (free_pr_out),
    .free_num     (free_num),
    .retire_valid (retire_valid),
    .Told_in      (Told_in),
    .BPRecoverEN  (BPRecoverEN)
`ifdef FREE_LIST_DEBUG_EN
    ,
    .free_array_disp (free_array_disp),
    .head_disp       (head_disp),
    .tail_disp       (tail_disp)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int e2, input int e1, input int e0, input int num);
    check({tag, " out[2]"}, 32'(free_pr_out[2]), 32'(e2));
    check({tag, " out[1]"}, 32'(free_pr_out[1]), 32'(e1));
    check({tag, " out[0]"}, 32'(free_pr_out[0]), 32'(e0));
    check({tag, " free_num"}, 32'(free_num), 32'(num));
  endtask

  task automatic drive(input int d, input logic [2:0] rv, input int t2, input int t1,
                       input int t0, input logic rec);
    dispatch_num = 2'(d);
    retire_valid = rv;
    Told_in[2]   = `PR'(t2);
    Told_in[1]   = `PR'(t1);
    Told_in[0]   = `PR'(t0);
    BPRecoverEN  = rec;
  endtask

  task automatic idle();
    drive(0, 3'b000, 0, 0, 0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  typedef struct {
    int         d;
    logic [2:0] rv;
    int         t2, t1, t0;
    logic       rec;
    int         e2, e1, e0, num;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int d, input logic [2:0] rv, input int t2, input int t1, input int t0,
                     input logic rec, input int e2, input int e1, input int e0, input int num);
    vec_t v;
    v.d = d; v.rv = rv; v.t2 = t2; v.t1 = t1; v.t0 = t0; v.rec = rec;
    v.e2 = e2; v.e1 = e1; v.e0 = e0; v.num = num;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b0;
    idle();

    // Reset values, both while reset is held and after it is released.
    repeat (2) @(posedge clock);
    #1 check_out("in reset", 32, 33, 34, 32);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 check_out("after reset", 32, 33, 34, 32);

    // Vector table. Each row gives the inputs for one cycle and the values
    // expected after that cycle's edge.
    add(3, 3'b000, 0, 0, 0, 0,  35, 36, 37, 29);
    add(3, 3'b000, 0, 0, 0, 0,  38, 39, 40, 26);
    add(2, 3'b101, 5, 0, 7, 0,  40, 41, 42, 26);  // dispatch + retire
    add(3, 3'b000, 0, 0, 0, 0,  43, 44, 45, 23);
    add(3, 3'b000, 0, 0, 0, 0,  46, 47, 48, 20);
    add(3, 3'b000, 0, 0, 0, 0,  49, 50, 51, 17);
    add(3, 3'b000, 0, 0, 0, 0,  52, 53, 54, 14);
    add(3, 3'b000, 0, 0, 0, 0,  55, 56, 57, 11);
    add(3, 3'b000, 0, 0, 0, 0,  58, 59, 60, 8);
    add(3, 3'b000, 0, 0, 0, 0,  61, 62, 63, 5);
    add(3, 3'b000, 0, 0, 0, 0,   5,  7, 34, 2);   // head wraps, retired 5,7 arrive
    add(1, 3'b000, 0, 0, 0, 0,   7, 34, 35, 1);
    add(3, 3'b000, 0, 0, 0, 0,  34, 35, 36, 0);   // underflow clamp: consumes 1
    add(3, 3'b000, 0, 0, 0, 0,  34, 35, 36, 0);   // empty: nothing consumed
    add(0, 3'b111, 10, 11, 12, 0, 10, 11, 12, 3);
    add(0, 3'b111, 20, 21, 22, 0, 10, 11, 12, 6);
    add(0, 3'b110, 23, 24, 0, 0,  10, 11, 12, 8);
    add(0, 3'b011, 0, 25, 26, 0,  10, 11, 12, 10);
    add(3, 3'b100, 27, 0, 0, 1,   45, 46, 47, 32); // recovery: head = tail = 13
    add(0, 3'b111, 1, 2, 3, 0,    45, 46, 47, 32); // retire into full: dropped
    add(3, 3'b000, 0, 0, 0, 0,    48, 49, 50, 29);

    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i].d, vecs[i].rv, vecs[i].t2, vecs[i].t1, vecs[i].t0, vecs[i].rec);
      @(posedge clock);
      #1 check_out($sformatf("vec%0d", i), vecs[i].e2, vecs[i].e1, vecs[i].e0, vecs[i].num);
    end

    // Wrap-around: drain everything, refill with tags 0..31, then drain one
    // at a time and check that each tag comes out in order.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      drive((i < 10) ? 3 : 2, 3'b000, 0, 0, 0, 1'b0);
    end
    @(negedge clock);
    idle();
    check("wrap empty free_num", 32'(free_num), 32'd0);
    check_out("wrap empty", 32, 33, 34, 0);
    for (int k = 0; k < 11; k++) begin
      @(negedge clock);
      if (k < 10) drive(0, 3'b111, 3*k, 3*k+1, 3*k+2, 1'b0);
      else        drive(0, 3'b110, 30, 31, 0, 1'b0);
      if (k == 0) begin
        // No forwarding: the first retired tag must not show up this cycle.
        #1 check("latency no bypass", 32'(free_pr_out[2]), 32'd32);
      end
    end
    @(negedge clock);
    idle();
    check_out("wrap full", 0, 1, 2, 32);
    for (int i = 0; i < 32; i++) begin
      @(negedge clock);
      check($sformatf("wrap drain %0d", i), 32'(free_pr_out[2]), 32'(i));
      drive(1, 3'b000, 0, 0, 0, 1'b0);
    end
    @(negedge clock);
    idle();
    check("wrap drained free_num", 32'(free_num), 32'd0);

    // Reset in mid-operation: it acts at once, and pending inputs are ignored.
    @(negedge clock);
    drive(3, 3'b111, 9, 9, 9, 1'b0);
    #2 reset = 1'b0;
    #1 check_out("async reset", 32, 33, 34, 32);
    @(posedge clock);
    #1 check_out("reset held", 32, 33, 34, 32);
    @(negedge clock);
    idle();
    reset = 1'b1;
    @(posedge clock);
    #1 check_out("reset released", 32, 33, 34, 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
